braille_pager: RTL and testbench
================================

Name: braille_pager

Overview:
- Parametrised successor to the fixed 4-cell reader.
- Buffers a serial stream of braille cell codes, up to DEPTH cells per message, then presents them N_CELLS at a time on a flat display bus.
- Pages are selected with next/prev controls, with optional wrap-around, blank-fill of a partial final page, and truncation reporting.
- Sits between the ASCII-to-braille translator output and the refreshable cell drivers.

Parameters:
- CELL_W, 8, bits per braille cell code.
- N_CELLS, 4, display cells per page. DEPTH must be a multiple of N_CELLS.
- DEPTH, 32, message buffer capacity in cells.
- WRAP, 0, when 1, next on the last page goes to page 0 and prev on page 0 goes to the last page. When 0, the page holds.
- BLANK, 0, cell code driven on cells beyond the message length.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_data  in  CELL_W  incoming cell code.
- in_valid  in  1  in_data valid.
- in_last  in  1  qualifies the final cell of a message (sampled with in_valid).
- in_ready  out  1  block can accept a cell this cycle.
- clear  in  1  synchronous flush to empty.
- next  in  1  advance page (rising-edge detected).
- prev  in  1  go back one page (rising-edge detected).
- cells_out  out  N_CELLS*CELL_W  page cells; cell i is at bits [i*CELL_W +: CELL_W], and cell 0 is the first cell of the page.
- cells_mask  out  N_CELLS  bit i is 1 when cell i holds message data.
- disp_valid  out  1  cells_out is showing a loaded message.
- page_idx  out  clog2(DEPTH/N_CELLS+1)  current page, aligned with cells_out.
- page_count  out  clog2(DEPTH/N_CELLS+1)  ceil(msg_len/N_CELLS).
- msg_len  out  clog2(DEPTH+1)  cells stored.
- truncated  out  1  message hit DEPTH without in_last.

Behaviour:
- Reset (async, reset=0): state EMPTY. All outputs are 0, except cells_out, which is all cells = BLANK. in_ready=0 while reset is asserted. next_q and prev_q are cleared.
- States: EMPTY, LOAD, SHOW.
- in_ready=1 in EMPTY and LOAD, 0 in SHOW. A beat is accepted when in_valid && in_ready.
- EMPTY: the first accepted beat writes buf[0], sets len=1 and moves to LOAD. If that beat carries in_last, the state goes straight to SHOW.
- LOAD: each accepted beat writes buf[len] and increments len.
  - Go to SHOW on the edge that accepts an in_last beat.
  - Also go to SHOW on the edge that accepts beat number DEPTH. In that case truncated=1 unless the beat carried in_last.
- Entering SHOW: internal page=0. On the following edge, cells_out, cells_mask, page_idx and disp_valid=1 are registered. Latency is 2 edges from acceptance of the final beat to disp_valid.
- Outputs are registered every cycle in SHOW from the internal page:
  - cell i = buf[page*N_CELLS+i] if page*N_CELLS+i < len; otherwise BLANK with mask bit 0.
- Page control in SHOW:
  - rise_n = next & ~next_q and rise_p = prev & ~prev_q, where next_q and prev_q are registered each cycle.
  - rise_n only: page+1. On the last page (page_count-1), go to 0 if WRAP, else hold.
  - rise_p only: page-1. On page 0, go to page_count-1 if WRAP, else hold.
  - rise_n and rise_p in the same cycle: no change.
  - A held next/prev advances once only.
  - Outputs reflect the new page 1 edge after the internal page update (2 edges after next first goes high).
- next/prev outside SHOW: ignored, but next_q and prev_q still track the inputs.
- clear (any state, highest priority after reset):
  - Next edge: state EMPTY; len, page and truncated = 0; disp_valid=0; cells BLANK; mask 0.
  - A beat presented with clear is not accepted (in_ready is still 1, but the write is suppressed).
- A new message is loaded only after clear. In SHOW, in_ready=0 and input is back-pressured.
- Async reset mid-LOAD or mid-SHOW discards all contents immediately.
- page_count and msg_len are valid from the first accepted beat; page_count updates each beat.

Test Plan:
- Default params; load 16 cells 8'h30..8'h3F, in_last on the 16th -> disp_valid 2 edges later, page_count=4, cells_out={33,32,31,30} (cell3..cell0), mask=4'hF. Four next pulses step pages 0-1-2-3; the next pulse holds page 3 (WRAP=0).
- WRAP=1, same load -> next on page 3 gives page 0 (cells 30..33); prev on page 0 gives page 3 (cells 3C..3F).
- Load 10 cells 8'h41..8'h4A -> page_count=3. Page 2 shows cells {BLANK,BLANK,4A,49}, mask=4'b0011. Holding next high for 5 cycles advances exactly one page. Simultaneous next/prev rising -> page unchanged.
- Stream 40 cells without in_last (DEPTH=32) -> in_ready drops after the 32nd accept, truncated=1, msg_len=32, page_count=8.
- Pulse clear mid-LOAD after 5 beats -> msg_len=0, state EMPTY, a fresh 4-cell load displays correctly. Assert reset=0 during SHOW -> all outputs clear immediately.

Source files
------------

// File: rtl/braille_pager.sv
// Paged braille cell buffer: collects a serial message of cell codes and
// presents it N_CELLS at a time, stepping pages on next/prev rising edges.
module braille_pager #(
  parameter int unsigned       CELL_W  = 8,
  parameter int unsigned       N_CELLS = 4,
  parameter int unsigned       DEPTH   = 32,
  parameter bit                WRAP    = 1'b0,
  parameter logic [CELL_W-1:0] BLANK   = '0
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [CELL_W-1:0]                    in_data,
  input  logic                                 in_valid,
  input  logic                                 in_last,
  output logic                                 in_ready,
  input  logic                                 clear,
  input  logic                                 next,
  input  logic                                 prev,
  output logic [N_CELLS*CELL_W-1:0]            cells_out,
  output logic [N_CELLS-1:0]                   cells_mask,
  output logic                                 disp_valid,
  output logic [$clog2(DEPTH/N_CELLS+1)-1:0]   page_idx,
  output logic [$clog2(DEPTH/N_CELLS+1)-1:0]   page_count,
  output logic [$clog2(DEPTH+1)-1:0]           msg_len,
  output logic                                 truncated
);

  localparam int unsigned PW = $clog2(DEPTH/N_CELLS+1);
  localparam int unsigned LW = $clog2(DEPTH+1);
  localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {EMPTY, LOAD, SHOW} state_e;

  state_e                    state_q, state_d;
  logic [LW-1:0]             len_q, len_d;
  logic [PW-1:0]             page_q, page_d;
  logic [PW-1:0]             pcount_q, pcount_d;
  logic                      trunc_q, trunc_d;
  logic                      next_q, prev_q;
  logic                      in_ready_q, in_ready_d;
  logic [N_CELLS*CELL_W-1:0] cells_q, cells_d;
  logic [N_CELLS-1:0]        mask_q, mask_d;
  logic                      dv_q, dv_d;
  logic [PW-1:0]             pidx_q, pidx_d;

  logic [CELL_W-1:0]         mem_q [DEPTH];
  logic                      wr_en;
  logic                      accept;
  logic                      rise_n, rise_p;
  logic                      at_full;
  logic [PW-1:0]             last_page;
  logic [31:0]               idx;

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    page_d     = page_q;
    trunc_d    = trunc_q;
    wr_en      = 1'b0;
    idx        = '0;
    rise_n     = next & ~next_q;
    rise_p     = prev & ~prev_q;
    accept     = in_valid & in_ready_q & ~clear;
    at_full    = (len_q == LW'(DEPTH-1));
    last_page  = pcount_q - PW'(1);

    if (clear) begin
      state_d = EMPTY;
      len_d   = '0;
      page_d  = '0;
      trunc_d = 1'b0;
    end else begin
      case (state_q)
        EMPTY, LOAD: begin
          if (accept) begin
            wr_en   = 1'b1;
            len_d   = len_q + LW'(1);
            state_d = LOAD;
            if (in_last || at_full) begin
              state_d = SHOW;
              page_d  = '0;
              trunc_d = at_full && !in_last;
            end
          end
        end
        SHOW: begin
          if (rise_n && !rise_p) begin
            if (page_q == last_page) page_d = WRAP ? '0 : page_q;
            else                     page_d = page_q + PW'(1);
          end else if (rise_p && !rise_n) begin
            if (page_q == '0) page_d = WRAP ? last_page : page_q;
            else              page_d = page_q - PW'(1);
          end
        end
        default: state_d = EMPTY;
      endcase
    end

    pcount_d   = PW'((32'(len_d) + N_CELLS - 1) / N_CELLS);
    in_ready_d = (state_d != SHOW);

    // Display registers lag the page register by one edge.
    cells_d = {N_CELLS{BLANK}};
    mask_d  = '0;
    dv_d    = 1'b0;
    pidx_d  = '0;
    if (!clear && state_q == SHOW) begin
      dv_d   = 1'b1;
      pidx_d = page_q;
      for (int unsigned i = 0; i < N_CELLS; i++) begin
        idx = 32'(page_q) * N_CELLS + i;
        if (idx < 32'(len_q)) begin
          cells_d[i*CELL_W +: CELL_W] = mem_q[idx[IW-1:0]];
          mask_d[i]                   = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= EMPTY;
      len_q      <= '0;
      page_q     <= '0;
      pcount_q   <= '0;
      trunc_q    <= 1'b0;
      next_q     <= 1'b0;
      prev_q     <= 1'b0;
      in_ready_q <= 1'b0;
      cells_q    <= {N_CELLS{BLANK}};
      mask_q     <= '0;
      dv_q       <= 1'b0;
      pidx_q     <= '0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      page_q     <= page_d;
      pcount_q   <= pcount_d;
      trunc_q    <= trunc_d;
      next_q     <= next;
      prev_q     <= prev;
      in_ready_q <= in_ready_d;
      cells_q    <= cells_d;
      mask_q     <= mask_d;
      dv_q       <= dv_d;
      pidx_q     <= pidx_d;
    end
  end

  // Storage is never read beyond len, so it needs no reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[len_q[IW-1:0]] <= in_data;
  end

  assign in_ready   = in_ready_q;
  assign cells_out  = cells_q;
  assign cells_mask = mask_q;
  assign disp_valid = dv_q;
  assign page_idx   = pidx_q;
  assign page_count = pcount_q;
  assign msg_len    = len_q;
  assign truncated  = trunc_q;

endmodule

// File: tb/tb_braille_pager.sv
// Bench for braille_pager: two instances (WRAP=0 and WRAP=1) share stimulus
// and are compared against a queue-based page model.
module tb_braille_pager;

  localparam int unsigned CW = 8;
  localparam int unsigned NC = 4;
  localparam int unsigned DP = 32;
  localparam int unsigned PW = $clog2(DP/NC+1);
  localparam int unsigned LW = $clog2(DP+1);
  localparam logic [CW-1:0] BL = 8'h00;

  logic clk = 1'b0;
  logic reset, in_valid, in_last, clear, next, prev;
  logic [CW-1:0] in_data;

  logic rdy0, rdy1, dv0, dv1, tr0, tr1;
  logic [NC*CW-1:0] c0, c1;
  logic [NC-1:0] m0, m1;
  logic [PW-1:0] pi0, pi1, pc0, pc1;
  logic [LW-1:0] ml0, ml1;

  int errors = 0;
  int checks = 0;

  logic [CW-1:0] mq[$];
  bit mshow, mtrunc;
  int mp0, mp1;

  always #5 clk = ~clk;

  braille_pager #(.CELL_W(CW), .N_CELLS(NC), .DEPTH(DP), .WRAP(1'b0), .BLANK(BL)) u0 (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
    .in_ready(rdy0), .clear(clear), .next(next), .prev(prev), .cells_out(c0),
    .cells_mask(m0), .disp_valid(dv0), .page_idx(pi0), .page_count(pc0),
    .msg_len(ml0), .truncated(tr0));

  braille_pager #(.CELL_W(CW), .N_CELLS(NC), .DEPTH(DP), .WRAP(1'b1), .BLANK(BL)) u1 (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
    .in_ready(rdy1), .clear(clear), .next(next), .prev(prev), .cells_out(c1),
    .cells_mask(m1), .disp_valid(dv1), .page_idx(pi1), .page_count(pc1),
    .msg_len(ml1), .truncated(tr1));

  function automatic int pcnt();
    return (mq.size() + NC - 1) / NC;
  endfunction

  function automatic int step(int p, bit rn, bit rp, bit wrap);
    int pc;
    pc = pcnt();
    if (rn && !rp) return wrap ? (p + 1) % pc : ((p + 1 < pc) ? p + 1 : p);
    if (rp && !rn) return wrap ? (p + pc - 1) % pc : ((p > 0) ? p - 1 : p);
    return p;
  endfunction

  function automatic logic [NC*CW-1:0] ecells(int p);
    logic [NC*CW-1:0] r;
    for (int i = 0; i < NC; i++)
      r[i*CW +: CW] = (p*NC + i < mq.size()) ? mq[p*NC + i] : BL;
    return r;
  endfunction

  function automatic logic [NC-1:0] emask(int p);
    logic [NC-1:0] r;
    for (int i = 0; i < NC; i++) r[i] = (p*NC + i < mq.size());
    return r;
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic model_clear();
    mq.delete(); mshow = 0; mtrunc = 0; mp0 = 0; mp1 = 0;
  endtask

  task automatic do_clear();
    clear = 1'b1; tick(); clear = 1'b0;
    model_clear();
    checks++; if (ml0 !== '0 || ml1 !== '0) begin errors++; $display("FAIL clear_len: got %0d/%0d want 0", ml0, ml1); end
    checks++; if (dv0 !== 1'b0 || m0 !== '0 || pc0 !== '0) begin errors++; $display("FAIL clear_disp: got dv=%b mask=%b pc=%0d want 0", dv0, m0, pc0); end
    checks++; if (c0 !== {NC{BL}}) begin errors++; $display("FAIL clear_cells: got %h want %h", c0, {NC{BL}}); end
    checks++; if (rdy0 !== 1'b1) begin errors++; $display("FAIL clear_ready: got %b want 1", rdy0); end
  endtask

  task automatic load(input int n, input bit use_last, input bit rnd, input logic [CW-1:0] base);
    for (int k = 0; k < n; k++) begin
      in_data  = rnd ? CW'($urandom) : base + CW'(k);
      in_valid = 1'b1;
      in_last  = use_last && (k == n - 1);
      checks++; if (rdy0 !== !mshow) begin errors++; $display("FAIL in_ready beat %0d: got %b want %b", k, rdy0, !mshow); end
      tick();
      if (!mshow) begin
        mq.push_back(in_data);
        if (in_last || mq.size() == DP) begin
          mshow = 1; mtrunc = !in_last; mp0 = 0; mp1 = 0;
        end
      end
    end
    in_valid = 1'b0; in_last = 1'b0;
    checks++; if (ml0 !== LW'(mq.size())) begin errors++; $display("FAIL msg_len: got %0d want %0d", ml0, mq.size()); end
    checks++; if (pc0 !== PW'(pcnt())) begin errors++; $display("FAIL page_count: got %0d want %0d", pc0, pcnt()); end
    checks++; if (tr0 !== mtrunc) begin errors++; $display("FAIL truncated: got %b want %b", tr0, mtrunc); end
  endtask

  task automatic press(input bit n, input bit p);
    next = n; prev = p; tick();
    mp0 = step(mp0, n, p, 1'b0);
    mp1 = step(mp1, n, p, 1'b1);
    next = 1'b0; prev = 1'b0; tick();
    checks++; if (pi0 !== PW'(mp0) || pi1 !== PW'(mp1)) begin errors++; $display("FAIL page_idx: got %0d/%0d want %0d/%0d", pi0, pi1, mp0, mp1); end
    checks++; if (c0 !== ecells(mp0)) begin errors++; $display("FAIL cells_nowrap: got %h want %h", c0, ecells(mp0)); end
    checks++; if (c1 !== ecells(mp1)) begin errors++; $display("FAIL cells_wrap: got %h want %h", c1, ecells(mp1)); end
    checks++; if (m0 !== emask(mp0) || m1 !== emask(mp1)) begin errors++; $display("FAIL mask: got %b/%b want %b/%b", m0, m1, emask(mp0), emask(mp1)); end
  endtask

  task automatic test_reset();
    reset = 1'b0; in_valid = 0; in_last = 0; in_data = '0; clear = 0; next = 0; prev = 0;
    #2;
    checks++; if ({rdy0, dv0, tr0, m0, pi0, pc0, ml0} !== '0) begin errors++; $display("FAIL reset_outputs: got %b want 0", {rdy0, dv0, tr0, m0, pi0, pc0, ml0}); end
    checks++; if (c0 !== {NC{BL}} || c1 !== {NC{BL}}) begin errors++; $display("FAIL reset_cells: got %h want %h", c0, {NC{BL}}); end
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    model_clear();
    tick();
    checks++; if (rdy0 !== 1'b1) begin errors++; $display("FAIL ready_after_reset: got %b want 1", rdy0); end
  endtask

  task automatic test_basic();
    load(16, 1'b1, 1'b0, 8'h30);
    checks++; if (dv0 !== 1'b0) begin errors++; $display("FAIL latency_early: got dv=%b want 0", dv0); end
    tick();
    checks++; if (dv0 !== 1'b1 || dv1 !== 1'b1) begin errors++; $display("FAIL latency: got dv=%b/%b want 1", dv0, dv1); end
    checks++; if (c0 !== 32'h33323130) begin errors++; $display("FAIL page0_cells: got %h want 33323130", c0); end
    checks++; if (m0 !== 4'hF || pc0 !== PW'(4)) begin errors++; $display("FAIL page0_mask: got mask=%h pc=%0d want F/4", m0, pc0); end
    for (int k = 0; k < 4; k++) press(1'b1, 1'b0);
    checks++; if (pi0 !== PW'(3) || c0 !== 32'h3F3E3D3C) begin errors++; $display("FAIL hold_last: got page %0d cells %h want 3 3F3E3D3C", pi0, c0); end
    checks++; if (pi1 !== PW'(0) || c1 !== 32'h33323130) begin errors++; $display("FAIL wrap_next: got page %0d cells %h want 0 33323130", pi1, c1); end
    press(1'b0, 1'b1);
    checks++; if (pi1 !== PW'(3) || c1 !== 32'h3F3E3D3C) begin errors++; $display("FAIL wrap_prev: got page %0d cells %h want 3 3F3E3D3C", pi1, c1); end
  endtask

  task automatic test_partial();
    do_clear();
    load(10, 1'b1, 1'b0, 8'h41);
    tick();
    checks++; if (pc0 !== PW'(3)) begin errors++; $display("FAIL partial_pc: got %0d want 3", pc0); end
    press(1'b1, 1'b0);
    press(1'b1, 1'b0);
    checks++; if (pi0 !== PW'(2) || c0 !== {BL, BL, 8'h4A, 8'h49} || m0 !== 4'b0011) begin errors++; $display("FAIL partial_page: got page %0d cells %h mask %b want 2 %h 0011", pi0, c0, {BL, BL, 8'h4A, 8'h49}, m0); end
    press(1'b0, 1'b1);
    next = 1'b1;
    repeat (5) tick();
    next = 1'b0;
    tick();
    mp0 = step(mp0, 1'b1, 1'b0, 1'b0);
    mp1 = step(mp1, 1'b1, 1'b0, 1'b1);
    checks++; if (pi0 !== PW'(mp0) || pi1 !== PW'(mp1)) begin errors++; $display("FAIL held_next: got %0d/%0d want %0d/%0d", pi0, pi1, mp0, mp1); end
    press(1'b1, 1'b1);
    checks++; if (pi0 !== PW'(2)) begin errors++; $display("FAIL both_edges: got %0d want 2", pi0); end
  endtask

  task automatic test_truncate();
    do_clear();
    load(40, 1'b0, 1'b1, 8'h00);
    checks++; if (tr0 !== 1'b1 || ml0 !== LW'(32) || pc0 !== PW'(8) || rdy0 !== 1'b0) begin errors++; $display("FAIL truncate: got tr=%b len=%0d pc=%0d rdy=%b want 1 32 8 0", tr0, ml0, pc0, rdy0); end
    tick();
    checks++; if (dv0 !== 1'b1 || c0 !== ecells(0)) begin errors++; $display("FAIL truncate_disp: got dv=%b cells %h want 1 %h", dv0, c0, ecells(0)); end
    for (int k = 0; k < 9; k++) press(1'b1, 1'b0);
    press(1'b0, 1'b1);
  endtask

  task automatic test_clear_midload();
    do_clear();
    load(5, 1'b0, 1'b1, 8'h00);
    do_clear();
    load(4, 1'b1, 1'b1, 8'h00);
    tick();
    checks++; if (dv0 !== 1'b1 || c0 !== ecells(0) || m0 !== 4'hF || pc0 !== PW'(1)) begin errors++; $display("FAIL fresh_load: got dv=%b cells %h mask %h pc %0d want 1 %h F 1", dv0, c0, m0, pc0, ecells(0)); end
    press(1'b1, 1'b0);
    press(1'b0, 1'b1);
  endtask

  task automatic test_random();
    int n;
    for (int it = 0; it < 6; it++) begin
      do_clear();
      n = $urandom_range(1, DP);
      load(n, 1'b1, 1'b1, 8'h00);
      tick();
      checks++; if (dv0 !== 1'b1 || c0 !== ecells(0) || m0 !== emask(0)) begin errors++; $display("FAIL rand_first len %0d: got dv=%b cells %h mask %b want 1 %h %b", n, dv0, c0, m0, ecells(0), emask(0)); end
      for (int k = 0; k < 8; k++) press(1'($urandom), 1'($urandom));
    end
  endtask

  task automatic test_reset_show();
    @(posedge clk); #2;
    reset = 1'b0;
    #2;
    checks++; if ({dv0, dv1, tr0, m0, pi0, pc0, ml0, rdy0} !== '0) begin errors++; $display("FAIL reset_show: got %b want 0", {dv0, dv1, tr0, m0, pi0, pc0, ml0, rdy0}); end
    checks++; if (c0 !== {NC{BL}}) begin errors++; $display("FAIL reset_show_cells: got %h want %h", c0, {NC{BL}}); end
    @(posedge clk); #1 reset = 1'b1;
    model_clear();
    tick();
    load(3, 1'b0, 1'b1, 8'h00);
    reset = 1'b0;
    #2;
    checks++; if (ml0 !== '0 || pc0 !== '0) begin errors++; $display("FAIL reset_load: got len %0d pc %0d want 0 0", ml0, pc0); end
    @(posedge clk); #1 reset = 1'b1;
    model_clear();
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_partial();
    test_truncate();
    test_clear_midload();
    test_random();
    test_reset_show();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
